minmax_sort_ctrl: RTL and testbench

Sequencing controller that time-shares one 8-bit min/max compare-exchange unit to sort a burst of N bytes in place. It collects N bytes over a valid/ready input stream, then runs a bubble sort issuing one compare-exchange per cycle through the shared unit. It then streams the sorted bytes out over a valid/ready output port. It sits between a byte producer and consumer in the lab datapath and is the only user of the min/max unit it drives.

---
 rtl/minmax_sort_ctrl.sv | 172 +++++++++++++++++
 tb/tb_minmax_sort_ctrl.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/minmax_sort_ctrl.sv
// minmax_sort_ctrl
// ----------------
// Collects a burst of N bytes from a valid/ready stream, bubble-sorts them in
// place with one shared min/max compare-exchange unit (one compare per cycle),
// then streams the sorted bytes out over a valid/ready port.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   producer has a byte on in_data
//   in_data    unsigned input byte
//   in_desc    sort order, sampled with the first byte (0 asc, 1 desc)
//   in_ready   high only while loading
//   out_valid  out_data holds a sorted byte
//   out_data   sorted byte, index 0 first (0 when not outputting)
//   out_ready  consumer accepts out_data
//   busy       high while sorting or outputting
//
// Build option:
//   MINMAX_SORT_EARLY_EXIT_EN  when defined, a pass that makes no exchange
//                              ends the sort early.

module minmax_sort_ctrl #(
  parameter int N = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  input  logic       in_desc,
  output logic       in_ready,
  output logic       out_valid,
  output logic [7:0] out_data,
  input  logic       out_ready,
  output logic       busy
);

  localparam int W  = $clog2(N) + 1;
  localparam int AW = $clog2(N);
  localparam logic [W-1:0] LAST_IDX = W'(N - 1);
  localparam logic [W-1:0] LAST_CMP = W'(N - 2);

  typedef enum logic [1:0] {ST_LOAD, ST_SORT, ST_OUT} state_t;

  state_t         state_reg, state_next;
  logic [W-1:0]   wr_idx_reg, rd_idx_reg, p_reg, i_reg;
  logic           desc_reg;
  logic           swap_reg;
  logic [7:0]     buf_reg  [N];
  logic [7:0]     buf_next [N];

  logic           in_fire, out_fire, sort_active;
  logic [W-1:0]   i_nxt;
  logic [7:0]     cmp_a, cmp_b, mm_min, mm_max, wr_lo, wr_hi;
  logic           a_gt_b, a_lt_b, swap_now;
  logic           pass_end, sort_done, early_exit;

  assign in_fire     = in_valid && (state_reg == ST_LOAD);
  assign out_fire    = out_ready && (state_reg == ST_OUT);
  assign sort_active = (state_reg == ST_SORT);
  assign i_nxt       = i_reg + W'(1);

  // Shared compare-exchange unit: adjacent pair buf[i], buf[i+1].
  assign cmp_a  = buf_reg[i_reg[AW-1:0]];
  assign cmp_b  = buf_reg[i_nxt[AW-1:0]];
  assign a_gt_b = (cmp_a > cmp_b);
  assign a_lt_b = (cmp_a < cmp_b);
  assign mm_min = a_gt_b ? cmp_b : cmp_a;
  assign mm_max = a_gt_b ? cmp_a : cmp_b;

  // Writeback order picks min/max by direction; an exchange only counts when
  // the pair is strictly out of order, so equal bytes never register a swap.
  assign wr_lo    = desc_reg ? mm_max : mm_min;
  assign wr_hi    = desc_reg ? mm_min : mm_max;
  assign swap_now = desc_reg ? a_lt_b : a_gt_b;

  assign pass_end = (i_reg == (LAST_CMP - p_reg));
`ifdef MINMAX_SORT_EARLY_EXIT_EN
  assign early_exit = !swap_reg && !swap_now;
`else
  assign early_exit = 1'b0;
`endif
  assign sort_done = sort_active && pass_end && ((p_reg == LAST_CMP) || early_exit);

  // Per-entry next value: load write, low or high half of the exchange.
  for (genvar gi = 0; gi < N; gi++) begin : g_entry
    localparam logic [W-1:0] IDX = W'(gi);
    assign buf_next[gi] = (in_fire && (wr_idx_reg == IDX))  ? in_data :
                          (sort_active && (i_reg == IDX))   ? wr_lo   :
                          (sort_active && (i_nxt == IDX))   ? wr_hi   :
                                                              buf_reg[gi];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < N; k++) buf_reg[k] <= '0;
    end else begin
      for (int k = 0; k < N; k++) buf_reg[k] <= buf_next[k];
    end
  end

  // Counters and captured sort direction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_idx_reg <= '0;
      rd_idx_reg <= '0;
      p_reg      <= '0;
      i_reg      <= '0;
      desc_reg   <= 1'b0;
      swap_reg   <= 1'b0;
    end else begin
      if (in_fire) begin
        wr_idx_reg <= wr_idx_reg + W'(1);
        if (wr_idx_reg == '0) desc_reg <= in_desc;
      end
      if (sort_active) begin
        if (pass_end) begin
          i_reg    <= '0;
          swap_reg <= 1'b0;
          p_reg    <= sort_done ? '0 : p_reg + W'(1);
        end else begin
          i_reg    <= i_nxt;
          swap_reg <= swap_reg | swap_now;
        end
      end
      if (out_fire) begin
        if (rd_idx_reg == LAST_IDX) begin
          rd_idx_reg <= '0;
          wr_idx_reg <= '0;
        end else begin
          rd_idx_reg <= rd_idx_reg + W'(1);
        end
      end
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= ST_LOAD;
    else        state_reg <= state_next;
  end

  // Next-state logic.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_LOAD: if (in_fire && (wr_idx_reg == LAST_IDX))   state_next = ST_SORT;
      ST_SORT: if (sort_done)                             state_next = ST_OUT;
      ST_OUT:  if (out_fire && (rd_idx_reg == LAST_IDX))  state_next = ST_LOAD;
      default:                                            state_next = ST_LOAD;
    endcase
  end

  // Outputs decoded from the state register (no path from in_valid/out_ready).
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    out_data  = 8'h00;
    case (state_reg)
      ST_LOAD: in_ready = 1'b1;
      ST_SORT: busy = 1'b1;
      ST_OUT: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        out_data  = buf_reg[rd_idx_reg[AW-1:0]];
      end
      default: in_ready = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_minmax_sort_ctrl.sv
module tb_minmax_sort_ctrl;

  localparam int N = 8;
  typedef logic [7:0] burst_t [N];

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid, in_desc, in_ready;
  logic [7:0] in_data;
  logic       out_valid, out_ready, busy;
  logic [7:0] out_data;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  minmax_sort_ctrl #(.N(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_desc   (in_desc),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .busy      (busy)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Drive N bytes, one handshake per rising edge; returns just after the
  // last handshake edge. With junk set, in_valid stays high with 8'hAA.
  task automatic load_burst(input burst_t d, input logic desc, input logic desc_late,
                            input logic junk);
    for (int j = 0; j < N; j++) begin
      @(negedge clk);
      check_val($sformatf("in_ready_load%0d", j), in_ready, 1);
      in_valid = 1'b1;
      in_data  = d[j];
      in_desc  = (j == 0) ? desc : desc_late;
      @(posedge clk);
    end
    #1;
    if (junk) begin
      in_valid = 1'b1;
      in_data  = 8'hAA;
      in_desc  = ~desc;
    end else begin
      in_valid = 1'b0;
    end
  endtask

  // Counts rising edges after the last input handshake until the first edge
  // that sees out_valid high (sampled on the preceding falling edge).
  task automatic wait_out(input string tag, input logic chk_lat, input int exp_lat);
    int cnt;
    cnt = 0;
    do begin
      @(negedge clk);
      cnt++;
      if (cnt == 1) begin
        check_val({tag, "_busy_sort"}, busy, 1);
        check_val({tag, "_inrdy_sort"}, in_ready, 0);
      end
    end while (!out_valid && cnt < 200);
    check_val({tag, "_outvalid_seen"}, out_valid, 1);
    if (chk_lat) check_val({tag, "_latency"}, cnt, exp_lat);
    $display("%s: out_valid after %0d edges", tag, cnt);
  endtask

  // Drain N bytes; with bp set, out_ready follows 1,0,0,1,...
  task automatic drain(input string tag, input burst_t e, input logic bp);
    logic [3:0] pat;
    int k, cyc;
    pat = 4'b1001;
    k   = 0;
    cyc = 0;
    while (k < N && cyc < 100) begin
      out_ready = bp ? pat[cyc % 4] : 1'b1;
      if (k == N - 1) in_valid = 1'b0;
      check_val($sformatf("%s_valid%0d", tag, k), out_valid, 1);
      check_val($sformatf("%s_data%0d", tag, k), out_data, e[k]);
      check_val($sformatf("%s_inrdy%0d", tag, k), in_ready, 0);
      @(posedge clk);
      if (out_ready) begin
        $display("%s: byte %0d = %0d", tag, k, out_data);
        k++;
      end
      cyc++;
      @(negedge clk);
    end
    out_ready = 1'b0;
    check_val({tag, "_count"}, k, N);
    check_val({tag, "_inrdy_after"}, in_ready, 1);
    check_val({tag, "_valid_after"}, out_valid, 0);
    check_val({tag, "_busy_after"}, busy, 0);
  endtask

  burst_t d_mix, e_asc, e_desc, d_junk, e_junk, d_rev, d_sorted;
  logic   lat_chk;

  initial begin
    d_mix    = '{8'd5, 8'd3, 8'd200, 8'd0, 8'd255, 8'd7, 8'd3, 8'd9};
    e_asc    = '{8'd0, 8'd3, 8'd3, 8'd5, 8'd7, 8'd9, 8'd200, 8'd255};
    e_desc   = '{8'd255, 8'd200, 8'd9, 8'd7, 8'd5, 8'd3, 8'd3, 8'd0};
    d_junk   = '{8'd9, 8'd9, 8'd1, 8'd128, 8'd64, 8'd2, 8'd250, 8'd0};
    e_junk   = '{8'd0, 8'd1, 8'd2, 8'd9, 8'd9, 8'd64, 8'd128, 8'd250};
    d_rev    = '{8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1};
    d_sorted = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8};
`ifdef MINMAX_SORT_EARLY_EXIT_EN
    lat_chk = 1'b0;
`else
    lat_chk = 1'b1;
`endif

    rst_n = 1'b0; in_valid = 1'b0; in_data = 8'h00; in_desc = 1'b0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    check_val("rst_in_ready", in_ready, 1);
    check_val("rst_out_valid", out_valid, 0);
    check_val("rst_out_data", out_data, 0);
    check_val("rst_busy", busy, 0);
    rst_n = 1'b1;

    // Ascending with the exact 29-edge latency.
    load_burst(d_mix, 1'b0, 1'b0, 1'b0);
    wait_out("asc", lat_chk, 29);
    drain("asc", e_asc, 1'b0);

    // Descending; in_desc toggled on later bytes must not matter.
    load_burst(d_mix, 1'b1, 1'b0, 1'b0);
    wait_out("desc", 1'b0, 0);
    drain("desc", e_desc, 1'b0);

    // Backpressure during output.
    load_burst(d_mix, 1'b0, 1'b1, 1'b0);
    wait_out("bp", 1'b0, 0);
    drain("bp", e_asc, 1'b1);

    // in_valid with 8'hAA while busy is ignored; the next burst is clean.
    load_burst(d_junk, 1'b0, 1'b0, 1'b1);
    wait_out("junk", 1'b0, 0);
    drain("junk", e_junk, 1'b0);
    load_burst(d_mix, 1'b1, 1'b1, 1'b0);
    wait_out("post_junk", 1'b0, 0);
    drain("post_junk", e_desc, 1'b0);

    // Reset in the middle of sorting.
    load_burst(d_mix, 1'b0, 1'b0, 1'b0);
    repeat (10) @(negedge clk);
    check_val("midsort_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    check_val("midrst_out_valid", out_valid, 0);
    check_val("midrst_busy", busy, 0);
    check_val("midrst_in_ready", in_ready, 1);
    check_val("midrst_out_data", out_data, 0);
    @(negedge clk);
    rst_n = 1'b1;
    load_burst(d_rev, 1'b0, 1'b0, 1'b0);
    wait_out("rev", 1'b1, 29);
    drain("rev", d_sorted, 1'b0);

    // Already-sorted input: 8 edges with early exit, 29 without.
    load_burst(d_sorted, 1'b0, 1'b0, 1'b0);
`ifdef MINMAX_SORT_EARLY_EXIT_EN
    wait_out("sorted", 1'b1, 8);
`else
    wait_out("sorted", 1'b1, 29);
`endif
    drain("sorted", d_sorted, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
